// File: rtl/beam_pkg.sv
// Shared defaults and state encoding for the beam row sequencer and its row buffer.
package beam_pkg;

  localparam int BEAM_WIDTH = 16;
  localparam int SPLIT_W    = 8;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_ARMED,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } seq_state_e;

endpackage

// File: rtl/beam_row_buffer.sv
// Row storage for one grid: single write port, async read port, write pointer and
// captured row count.
module beam_row_buffer
  import beam_pkg::*;
#(
  parameter int WIDTH    = BEAM_WIDTH,
  parameter int MAX_ROWS = 32,
  parameter int ROW_AW   = 5
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              wr_en,
  input  logic              wr_last,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              ptr_rst,
  input  logic [ROW_AW-1:0] rd_ptr,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ROW_AW:0]   row_count,
  output logic              load_done,
  output logic              filled
);

  logic [WIDTH-1:0]  mem [MAX_ROWS];
  logic [ROW_AW-1:0] wr_ptr;
  logic              at_top;

  assign at_top    = (wr_ptr == ROW_AW'(MAX_ROWS - 1));
  assign load_done = wr_en && (wr_last || at_top);
  // Reaching the last slot without row_last means the grid did not fit.
  assign filled    = wr_en && at_top && !wr_last;
  assign rd_data   = mem[rd_ptr];

  // Content is don't-care after reset, so the array carries no reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wr_ptr    <= '0;
      row_count <= '0;
    end else begin
      if (ptr_rst)    wr_ptr <= '0;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (load_done)  row_count <= {1'b0, wr_ptr} + 1'b1;
    end
  end

endmodule

// File: rtl/beam_row_sequencer.sv
// Buffers a grid of rows, walks it row by row through the beam engine, and reports
// the final beam and total split count. BEAM_SEQ_SATURATE_EN selects a saturating total.
module beam_row_sequencer
  import beam_pkg::*;
#(
  parameter int WIDTH    = BEAM_WIDTH,
  parameter int MAX_ROWS = 32,
  parameter int ROW_AW   = 5,
  parameter int TOTAL_W  = 16
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [WIDTH-1:0]   row_data,
  input  logic               row_valid,
  input  logic               row_last,
  output logic               row_ready,
  input  logic [WIDTH-1:0]   start_beam,
  input  logic               run,
  output logic [WIDTH-1:0]   eng_grid,
  output logic [WIDTH-1:0]   eng_beam,
  output logic               eng_start,
  input  logic [WIDTH-1:0]   eng_beam_out,
  input  logic               eng_done,
  input  logic [SPLIT_W-1:0] eng_split_count,
  output logic [WIDTH-1:0]   result_beam,
  output logic [TOTAL_W-1:0] total_splits,
  output logic               busy,
  output logic               finished,
  output logic               overflow
);

  localparam int SUM_W = ((TOTAL_W > SPLIT_W) ? TOTAL_W : SPLIT_W) + 1;

  seq_state_e        state, state_nx;
  logic [WIDTH-1:0]  beam_reg;
  logic [WIDTH-1:0]  rd_data;
  logic [ROW_AW-1:0] rd_ptr;
  logic [ROW_AW:0]   row_count;
  logic [TOTAL_W-1:0] total, total_nx;
  logic [SUM_W-1:0]  sum;
  logic              load_done, filled, row_accept, last_row;

  beam_row_buffer #(
    .WIDTH    (WIDTH),
    .MAX_ROWS (MAX_ROWS),
    .ROW_AW   (ROW_AW)
  ) u_buf (
    .clock     (clock),
    .clear     (clear),
    .wr_en     (row_accept),
    .wr_last   (row_last),
    .wr_data   (row_data),
    .ptr_rst   (state == ST_FINISH),
    .rd_ptr    (rd_ptr),
    .rd_data   (rd_data),
    .row_count (row_count),
    .load_done (load_done),
    .filled    (filled)
  );

  assign row_ready  = (state == ST_LOAD);
  assign row_accept = row_valid && row_ready;
  assign busy       = (state == ST_ISSUE) || (state == ST_WAIT);
  assign last_row   = ({1'b0, rd_ptr} == row_count - 1'b1);
  assign sum        = SUM_W'(total) + SUM_W'(eng_split_count);

`ifdef BEAM_SEQ_SATURATE_EN
  assign total_nx = (sum > SUM_W'({TOTAL_W{1'b1}})) ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
`else
  assign total_nx = sum[TOTAL_W-1:0];
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= ST_LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    eng_start = 1'b0;
    finished  = 1'b0;
    eng_grid  = '0;
    eng_beam  = '0;
    case (state)
      ST_LOAD:   if (load_done) state_nx = ST_ARMED;
      ST_ARMED:  if (run) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        eng_start = 1'b1;
        eng_grid  = rd_data;
        eng_beam  = beam_reg;
        state_nx  = ST_WAIT;
      end
      ST_WAIT: begin
        eng_grid = rd_data;
        eng_beam = beam_reg;
        if (eng_done) state_nx = last_row ? ST_FINISH : ST_ISSUE;
      end
      ST_FINISH: begin
        finished = 1'b1;
        state_nx = ST_LOAD;
      end
      default:   state_nx = ST_LOAD;
    endcase
  end

  // Results load on the WAIT->FINISH edge so they are already valid while finished=1.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      beam_reg     <= '0;
      rd_ptr       <= '0;
      total        <= '0;
      result_beam  <= '0;
      total_splits <= '0;
      overflow     <= 1'b0;
    end else begin
      if (row_accept) overflow <= filled;
      if (state == ST_ARMED && run) begin
        beam_reg <= start_beam;
        rd_ptr   <= '0;
        total    <= '0;
      end
      if (state == ST_WAIT && eng_done) begin
        beam_reg <= eng_beam_out;
        total    <= total_nx;
        if (last_row) begin
          result_beam  <= eng_beam_out;
          total_splits <= total_nx;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/beam_row_sequencer.md
# beam_row_sequencer

Upstream controller for the beam inference engine. Buffers one grid of manifold rows from a valid/ready stream, then walks the rows top to bottom. For each row it drives the engine, carries the returned beam vector into the next row and accumulates the engine's per-row split counts. It reports the final beam vector and the total split count.

## Interface
- WIDTH, 16, row/beam vector width; must match engine
- MAX_ROWS, 32, row buffer depth
- ROW_AW, 5, row pointer width; clog2(MAX_ROWS)
- TOTAL_W, 16, total split accumulator width
- clock  in  1  sole clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- row_data  in  WIDTH  grid row; bit=1 marks a splitter
- row_valid  in  1  row_data valid
- row_last  in  1  qualifies final row of grid
- row_ready  out  1  buffer accepting rows
- start_beam  in  WIDTH  initial beam vector, sampled on accepted run
- run  in  1  begin processing buffered grid
- eng_grid  out  WIDTH  to engine grid_in
- eng_beam  out  WIDTH  to engine beam_in
- eng_start  out  1  to engine start
- eng_beam_out  in  WIDTH  from engine beam_out
- eng_done  in  1  from engine done_
- eng_split_count  in  8  from engine split_count
- result_beam  out  WIDTH  final beam vector, held until next run
- total_splits  out  TOTAL_W  accumulated splits
- busy  out  1  high in ISSUE/WAIT
- finished  out  1  one-cycle pulse when result is valid
- overflow  out  1  sticky; buffer filled before row_last

## Operation
- States: LOAD, ARMED, ISSUE, WAIT, FINISH. Reset state is LOAD.
- LOAD:
  - row_ready=1.
  - On row_valid&row_ready, write buf[wr_ptr] and increment wr_ptr.
  - If row_last is set, or wr_ptr==MAX_ROWS-1, set row_count=wr_ptr+1 and go to ARMED.
  - The second condition without row_last sets overflow.
- ARMED:
  - row_ready=0.
  - On run: beam_reg<=start_beam, rd_ptr<=0, total<=0, clear overflow only in LOAD re-entry (see FINISH), then go to ISSUE.
- run is ignored in every state except ARMED. Row inputs are ignored whenever row_ready=0.
- ISSUE: eng_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - eng_grid=buf[rd_ptr] and eng_beam=beam_reg, both held stable. They are also driven stable in ISSUE.
  - On eng_done: beam_reg<=eng_beam_out and total<=total+zero-extended eng_split_count.
  - If rd_ptr==row_count-1, go to FINISH. Otherwise rd_ptr++ and go to ISSUE.
- FINISH:
  - result_beam<=beam_reg and total_splits<=total.
  - finished=1 for this cycle.
  - wr_ptr<=0, then go to LOAD. overflow is cleared on the first row accepted afterwards.
- The sequencer never drives the engine's clear and never issues start while in WAIT.
- Arithmetic: the accumulator is TOTAL_W bits. Overflow handling is set by configuration.

## Timing
- Reset values: row_ready=1, eng_start=0, eng_grid=0, eng_beam=0, result_beam=0, total_splits=0, busy=0, finished=0, overflow=0.
- Reset mid-run aborts immediately; the buffer content is don't-care.
- Row acceptance: one row per cycle at full throughput.
- Run to first eng_start: 1 cycle (ARMED→ISSUE).
- Per row: ISSUE (1) + WAIT until eng_done.
  - With the current engine (16 run counts + done) this is 19 cycles per row.
  - Correctness must depend only on eng_done, never on a fixed count.
- eng_done is sampled combinationally in WAIT. The next ISSUE follows the cycle after, when the engine is back in idle.
- result_beam/total_splits update in the FINISH cycle and are valid while finished=1; they hold afterwards.

## Configuration
- BEAM_SEQ_SATURATE_EN defined: total saturates at 2^TOTAL_W-1 and stays there.
- Undefined: total wraps modulo 2^TOTAL_W.

## Structure
- Shared package beam_pkg:
  - WIDTH default
  - state enum (LOAD, ARMED, ISSUE, WAIT, FINISH)
  - split count width (8)
- One sub-module, beam_row_buffer: MAX_ROWS x WIDTH register file with one write port and one async-read port, plus wr_ptr/row_count.
- The FSM and accumulator live in the top.

## Test plan
- Reset behaviour: assert clear mid-WAIT -> all outputs return to reset values; row_ready=1 next cycle; engine never sees a stray eng_start.
- Two-row grid: rows 0x0100, 0x0280 (row_last), start_beam=0x0100, run -> row1 eng_beam=0x0280; result_beam=0x0540, total_splits=3, finished pulse once.
- Single row with no splitter hit: row 0x0001 (row_last), start_beam=0x8000 -> result_beam=0x8000, total_splits=0, exactly one eng_start issued.
- Buffer fill: feed 32 rows without row_last -> 32nd accepted, row_ready drops, overflow=1, 32 eng_start pulses after run.
- Protocol: run pulsed during LOAD and during WAIT -> ignored; eng_grid/eng_beam stable from ISSUE through eng_done; stretching eng_done by a slow engine model (40 cycles) -> same result.
- Accumulator overflow: TOTAL_W=8, 20 rows each yielding split count 16 -> total_splits=0xFF with BEAM_SEQ_SATURATE_EN, 0x40 without.
